// File: rtl/quantizer_constant.svh
// rtl/quantizer_constant.svh - default Cr quantization table, row-major {row,col}
localparam logic [15:0] Q_MATRIX [0:63] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99
};

// File: rtl/cr_dequantizer.sv
// rtl/cr_dequantizer.sv - Cr dequantizer: coefficient x table entry, saturate, 8x8 block handoff
// Define CR_DEQ_PINGPONG_EN for two alternating output banks (full-rate streaming).
module cr_dequantizer #(
    parameter int CW = 11,
    parameter int QW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [CW-1:0] in_coef,
    input  logic                 tbl_we,
    input  logic [5:0]           tbl_addr,
    input  logic [QW-1:0]        tbl_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [CW-1:0] Z [0:7][0:7]
);

`include "quantizer_constant.svh"

`ifdef CR_DEQ_PINGPONG_EN
    localparam int   NB = 2;
    localparam logic PP = 1'b1;
`else
    localparam int   NB = 1;
    localparam logic PP = 1'b0;
`endif

    localparam int PW = CW + QW + 1;
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (CW - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic [QW-1:0]        tbl [0:63];
    logic [5:0]           idx;
    logic                 fill_bank;
    logic                 out_bank;
    // busy: coefficient 63 accepted, bank not yet handed off; full: last write landed
    logic [NB-1:0]        busy;
    logic [NB-1:0]        busy_n;
    logic [NB-1:0]        full;
    logic [NB-1:0]        full_n;
    logic                 s1_valid;
    logic signed [PW-1:0] s1_prod;
    logic [5:0]           s1_idx;
    logic                 s1_bank;
    logic signed [PW-1:0] coef_ext;
    logic signed [PW-1:0] q_ext;
    logic signed [CW-1:0] sat;
    logic                 accept;
    logic                 handoff;
    logic signed [CW-1:0] bank [0:NB-1][0:7][0:7];

    assign in_ready = ~busy[fill_bank];
    assign accept   = in_valid & in_ready;
    assign handoff  = out_valid & out_ready;
    assign coef_ext = PW'(in_coef);
    assign q_ext    = PW'({1'b0, tbl[idx]});
    assign Z        = bank[out_bank];

    always_comb begin
        if (s1_prod > SAT_MAX)
            sat = SAT_MAX[CW-1:0];
        else if (s1_prod < SAT_MIN)
            sat = SAT_MIN[CW-1:0];
        else
            sat = s1_prod[CW-1:0];
    end

    always_comb begin
        busy_n = busy;
        full_n = full;
        if (handoff) begin
            busy_n[out_bank] = 1'b0;
            full_n[out_bank] = 1'b0;
        end
        if (accept && idx == 6'd63)
            busy_n[fill_bank] = 1'b1;
        if (s1_valid && s1_idx == 6'd63)
            full_n[s1_bank] = 1'b1;
    end

    // Accepts read the table combinationally, so a same-cycle write is seen only by later accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++)
                tbl[6'(i)] <= QW'(Q_MATRIX[6'(i)]);
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            fill_bank <= 1'b0;
            out_bank  <= 1'b0;
            busy      <= '0;
            full      <= '0;
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_idx    <= '0;
            s1_bank   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            busy     <= busy_n;
            full     <= full_n;
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= coef_ext * q_ext;
                s1_idx  <= idx;
                s1_bank <= fill_bank;
                idx     <= idx + 6'd1;
                if (idx == 6'd63)
                    fill_bank <= fill_bank ^ PP;
            end
            // out_valid trails full by one cycle; after a handoff the other bank may already be full
            if (handoff) begin
                out_bank  <= out_bank ^ PP;
                out_valid <= PP & full[out_bank ^ PP];
            end else begin
                out_valid <= full[out_bank];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bank <= '{default: '0};
        else if (s1_valid)
            bank[s1_bank][s1_idx[5:3]][s1_idx[2:0]] <= sat;
    end

endmodule

// File: tb/tb_cr_dequantizer.sv
// tb/tb_cr_dequantizer.sv - self-checking bench for cr_dequantizer with block-level reference model
module tb_cr_dequantizer;
    localparam int CW = 11;
    localparam int QW = 16;
`ifdef CR_DEQ_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [CW-1:0] in_coef = '0;
    logic                 tbl_we = 1'b0;
    logic [5:0]           tbl_addr = '0;
    logic [QW-1:0]        tbl_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [CW-1:0] Z [0:7][0:7];

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    cr_dequantizer #(.CW(CW), .QW(QW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .out_valid(out_valid), .out_ready(out_ready), .Z(Z)
    );

    int q_default [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    function automatic int sat(input int p);
        if (p > 1023) return 1023;
        if (p < -1024) return -1024;
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: blocks complete when coefficient 63 is accepted and are due 3 cycles later
    typedef int blk_t [64];
    int   mtbl [64];
    int   cur [64];
    blk_t blk_q [$];
    int   rdy_q [$];
    int   hs_q [$];
    int   mk = 0;
    int   cyc = 0;
    bit   exp_ov = 1'b0;
    bit   exp_ir = 1'b1;
    bit   live = 1'b0;
    int   zbad;

    always @(posedge clk) begin
        if (rst) begin
            mtbl = q_default;
            mk = 0;
            blk_q.delete();
            rdy_q.delete();
            live = 1'b1;
        end else begin
            if (exp_ov && out_ready) begin
                void'(blk_q.pop_front());
                void'(rdy_q.pop_front());
                hs_q.push_back(cyc);
            end
            if (in_valid && exp_ir) begin
                cur[mk] = sat(int'(in_coef) * mtbl[mk]);
                if (mk == 63) begin
                    blk_q.push_back(cur);
                    rdy_q.push_back(cyc + 3);
                end
                mk = (mk + 1) % 64;
            end
            if (tbl_we)
                mtbl[tbl_addr] = int'(tbl_data);
        end
        cyc++;
        exp_ir = blk_q.size() < NB;
        exp_ov = rdy_q.size() > 0 && rdy_q[0] <= cyc;
    end

    always @(negedge clk) begin
        if (live && !rst) begin
            check("in_ready", int'(in_ready), int'(exp_ir));
            check("out_valid", int'(out_valid), int'(exp_ov));
            if (exp_ov) begin
                zbad = -1;
                for (int i = 0; i < 64; i++)
                    if (zbad < 0 && int'(Z[3'(i / 8)][3'(i % 8)]) != blk_q[0][i])
                        zbad = i;
                checks++;
                if (zbad >= 0) begin
                    errors++;
                    $display("FAIL Z_model[%0d][%0d]: got %0d expected %0d", zbad / 8, zbad % 8,
                             int'(Z[3'(zbad / 8)][3'(zbad % 8)]), blk_q[0][zbad]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_tbl(input int a, input int d);
        tbl_we = 1'b1;
        tbl_addr = 6'(a);
        tbl_data = QW'(d);
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic send(input int v, input bit we, input int a, input int d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_coef = CW'(v);
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        stalls += n;
        tbl_we = we;
        tbl_addr = 6'(a);
        tbl_data = QW'(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tbl_we = 1'b0;
    endtask

    task automatic wait_ov();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("wait_out_valid", int'(out_valid), 1);
    endtask

    task automatic zero_check(input string name);
        int nz;
        nz = 0;
        for (int i = 0; i < 64; i++)
            if (Z[3'(i / 8)][3'(i % 8)] != '0) nz++;
        check(name, nz, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        zero_check("rst_Z_nonzero");
        tick();

        // Test 1: table all 2, ramp k-32, exact latency
        for (int a = 0; a < 64; a++) wr_tbl(a, 2);
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) send(k - 32, 1'b0, 0, 0);
        @(negedge clk);
        check("t1_ov_T+1", int'(out_valid), 0);
        @(negedge clk);
        check("t1_ov_T+2", int'(out_valid), 0);
        @(negedge clk);
        check("t1_ov_T+3", int'(out_valid), 1);
        check("t1_Z00", int'(Z[0][0]), -64);
        check("t1_Z41", int'(Z[4][1]), 2);
        check("t1_Z77", int'(Z[7][7]), 62);
        tick();

        // Test 2: saturation at both rails
        wr_tbl(0, 100);
        wr_tbl(1, 100);
        wr_tbl(2, 1);
        out_ready = 1'b0;
        send(20, 1'b0, 0, 0);
        send(-20, 1'b0, 0, 0);
        send(-1024, 1'b0, 0, 0);
        send(511, 1'b0, 0, 0);
        send(512, 1'b0, 0, 0);
        for (int k = 5; k < 64; k++) send((k % 7) - 3, 1'b0, 0, 0);
        wait_ov();
        check("t2_Z00_sat_hi", int'(Z[0][0]), 1023);
        check("t2_Z01_sat_lo", int'(Z[0][1]), -1024);
        check("t2_Z02_min", int'(Z[0][2]), -1024);
        check("t2_Z03", int'(Z[0][3]), 1022);
        check("t2_Z04_sat_hi", int'(Z[0][4]), 1023);

        // Test 3: hold output with out_ready low
        tick();
        in_valid = (NB == 1);
        in_coef = CW'(5);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t3_hold_in_ready", int'(in_ready), (NB == 2) ? 1 : 0);
            check("t3_hold_ov", int'(out_valid), 1);
            check("t3_hold_Z00", int'(Z[0][0]), 1023);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_ov_at_hs", int'(out_valid), 1);
        @(negedge clk);
        check("t3_ov_after_hs", int'(out_valid), 0);
        check("t3_ir_after_hs", int'(in_ready), 1);
        tick();

        // Test 4: reset mid-block restores table and index
        wr_tbl(0, 7);
        for (int k = 0; k < 30; k++) send(3, 1'b0, 0, 0);
        in_valid = 1'b1;
        in_coef = CW'(9);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_ov", int'(out_valid), 0);
        check("t4_ir", int'(in_ready), 1);
        zero_check("t4_Z_nonzero");
        tick();
        for (int k = 0; k < 64; k++) send(1, 1'b0, 0, 0);
        wait_ov();
        check("t4_Z00_qmatrix", int'(Z[0][0]), 17);
        check("t4_Z11_qmatrix", int'(Z[1][1]), 21);
        check("t4_Z77_qmatrix", int'(Z[7][7]), 99);
        tick();

        // Test 5: table write colliding with accept of the same index
        wr_tbl(5, 1);
        for (int k = 0; k < 64; k++) send(4, k == 5, 5, 3);
        wait_ov();
        check("t5_Z05_old", int'(Z[0][5]), 4);
        check("t5_Z00", int'(Z[0][0]), 68);
        tick();
        for (int k = 0; k < 64; k++) send(4, 1'b0, 0, 0);
        wait_ov();
        check("t5_Z05_new", int'(Z[0][5]), 12);
        tick();

`ifdef CR_DEQ_PINGPONG_EN
        // Test 6: three back-to-back blocks at full rate
        repeat (5) tick();
        hs_q.delete();
        stalls = 0;
        for (int i = 0; i < 192; i++) send(((i * 7) % 61) - 30, 1'b0, 0, 0);
        repeat (8) tick();
        check("t6_stalls", stalls, 0);
        check("t6_handshakes", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("t6_gap01", hs_q[1] - hs_q[0], 64);
            check("t6_gap12", hs_q[2] - hs_q[1], 64);
        end
`endif

        n = 0;
        while ((blk_q.size() > 0 || out_valid) && n < 300) begin
            n++;
            tick();
        end
        check("drain_queue", blk_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
